// File: rtl/rf_write_ctrl_pkg.sv
// rtl/rf_write_ctrl_pkg.sv - shared defaults and state encoding for the register-file write controller
package rf_write_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NREGS_DEF  = 16;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SCRUB = 1'b1;

endpackage

// File: rtl/rf_write_ctrl_arb.sv
// rtl/rf_write_ctrl_arb.sv - two-way round-robin picker producing a one-hot grant
module rr_arb2 (
  input  logic [1:0] i_elig,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // i_ptr names the requester that wins a tie
  always_comb begin
    o_grant = 2'b00;
    if (i_elig == 2'b11) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end else begin
      o_grant = i_elig;
    end
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// rtl/rf_write_ctrl.sv - arbitrates two register-file writers and sweeps the file to zero on request
module rf_write_ctrl
  import rf_write_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  input  logic              scrub_req,
  output logic [DATA_W-1:0] rf_c,
  output logic [ADDR_W-1:0] rf_caddr,
  output logic              rf_load,
  output logic              ack0,
  output logic              ack1,
  output logic              busy,
  output logic              scrub_done
);

  // one extra bit lets the counter reach NREGS, marking the post-sweep done cycle
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] SCRUB_END = CNT_W'(NREGS);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ptr;
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;

  // a requester whose ack is showing this cycle is already served
  assign w_elig = {req1 & ~ack1, req0 & ~ack0};

  rr_arb2 u_arb (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ptr      <= 1'b0;
      rf_c       <= '0;
      rf_caddr   <= '0;
      rf_load    <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      scrub_done <= 1'b0;
    end else begin
      rf_load    <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      scrub_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (scrub_req) begin
            r_state <= ST_SCRUB;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end else if (w_grant[0]) begin
            rf_load  <= 1'b1;
            rf_caddr <= addr0;
            rf_c     <= data0;
            ack0     <= 1'b1;
            r_ptr    <= 1'b1;
          end else if (w_grant[1]) begin
            rf_load  <= 1'b1;
            rf_caddr <= addr1;
            rf_c     <= data1;
            ack1     <= 1'b1;
            r_ptr    <= 1'b0;
          end
        end
        default: begin
          if (r_cnt == SCRUB_END) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            busy       <= 1'b0;
            scrub_done <= 1'b1;
          end else begin
            rf_load  <= 1'b1;
            rf_caddr <= r_cnt[ADDR_W-1:0];
            rf_c     <= '0;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb/tb_rf_write_ctrl.sv - directed and randomized self-checking bench for rf_write_ctrl
module tb_rf_write_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          clear;
  logic          req0, req1, scrub_req;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic [DW-1:0] rf_c;
  logic [AW-1:0] rf_caddr;
  logic          rf_load, ack0, ack1, busy, scrub_done;

  int n_pass = 0;
  int n_total = 0;

  rf_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .clk        (clk),
    .clear      (clear),
    .req0       (req0),
    .addr0      (addr0),
    .data0      (data0),
    .req1       (req1),
    .addr1      (addr1),
    .data1      (data1),
    .scrub_req  (scrub_req),
    .rf_c       (rf_c),
    .rf_caddr   (rf_caddr),
    .rf_load    (rf_load),
    .ack0       (ack0),
    .ack1       (ack1),
    .busy       (busy),
    .scrub_done (scrub_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; req0 = 0; req1 = 0; scrub_req = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    tick();
    n_total++;
    if ({rf_load, ack0, ack1, busy, scrub_done, rf_c, rf_caddr} !== '0)
      $display("FAIL reset_outputs: got load=%b ack0=%b ack1=%b busy=%b done=%b c=%0h caddr=%0h, expected all 0",
               rf_load, ack0, ack1, busy, scrub_done, rf_c, rf_caddr);
    else n_pass++;
    clear = 1'b0;
    tick();
    n_total++;
    if ({rf_load, ack0, ack1, busy} !== 4'b0)
      $display("FAIL reset_idle: got load=%b ack0=%b ack1=%b busy=%b, expected 0000", rf_load, ack0, ack1, busy);
    else n_pass++;
  endtask

  task automatic test_single_write();
    req0 = 1; addr0 = 4; data0 = 15;
    tick();
    n_total++;
    if ({rf_load, ack0, ack1, rf_caddr, rf_c} !== {3'b110, 4'd4, 16'd15})
      $display("FAIL single_grant: got load=%b ack0=%b ack1=%b caddr=%0d c=%0d, expected 1 1 0 4 15",
               rf_load, ack0, ack1, rf_caddr, rf_c);
    else n_pass++;
    req0 = 0;
    tick();
    n_total++;
    if ({rf_load, ack0, rf_caddr, rf_c} !== {2'b00, 4'd4, 16'd15})
      $display("FAIL single_hold: got load=%b ack0=%b caddr=%0d c=%0d, expected 0 0 4 15", rf_load, ack0, rf_caddr, rf_c);
    else n_pass++;
    tick();
    n_total++;
    if ({rf_load, ack0, ack1} !== 3'b000)
      $display("FAIL single_no_regrant: got load=%b ack0=%b ack1=%b, expected 000", rf_load, ack0, ack1);
    else n_pass++;
  endtask

  task automatic test_contention();
    do_clear();
    req0 = 1; addr0 = 4; data0 = 15;
    req1 = 1; addr1 = 5; data1 = 30;
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = (k % 2 == 0) ? 4'd4 : 4'd5;
      ed = (k % 2 == 0) ? 16'd15 : 16'd30;
      tick();
      n_total++;
      if ({rf_load, ack0, ack1, rf_caddr, rf_c} !== {1'b1, (k % 2 == 0), (k % 2 == 1), ea, ed})
        $display("FAIL contention_%0d: got load=%b ack0=%b ack1=%b caddr=%0d c=%0d, expected 1 %0d %0d %0d %0d",
                 k, rf_load, ack0, ack1, rf_caddr, rf_c, (k % 2 == 0), (k % 2 == 1), ea, ed);
      else n_pass++;
    end
    req0 = 0; req1 = 0;
    tick();
    n_total++;
    if ({rf_load, ack0, ack1} !== 3'b000)
      $display("FAIL contention_drop: got load=%b ack0=%b ack1=%b, expected 000", rf_load, ack0, ack1);
    else n_pass++;
  endtask

  task automatic test_scrub();
    scrub_req = 1;
    tick();
    scrub_req = 0;
    n_total++;
    if ({busy, rf_load, ack0, ack1} !== 4'b1000)
      $display("FAIL scrub_start: got busy=%b load=%b ack0=%b ack1=%b, expected 1000", busy, rf_load, ack0, ack1);
    else n_pass++;
    for (int i = 0; i < NR; i++) begin
      tick();
      n_total++;
      if ({rf_load, busy, scrub_done, rf_caddr, rf_c} !== {3'b110, AW'(i), 16'd0})
        $display("FAIL scrub_write_%0d: got load=%b busy=%b done=%b caddr=%0d c=%0h, expected 1 1 0 %0d 0",
                 i, rf_load, busy, scrub_done, rf_caddr, rf_c, i);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({scrub_done, busy, rf_load} !== 3'b100)
      $display("FAIL scrub_done: got done=%b busy=%b load=%b, expected 1 0 0", scrub_done, busy, rf_load);
    else n_pass++;
    tick();
    n_total++;
    if ({scrub_done, busy, rf_load} !== 3'b000)
      $display("FAIL scrub_after: got done=%b busy=%b load=%b, expected 000", scrub_done, busy, rf_load);
    else n_pass++;
  endtask

  task automatic test_scrub_vs_req();
    bit early_ack = 0;
    int done_cyc = -1;
    int ack_cyc = -1;
    logic [AW-1:0] got_a = '0;
    logic [DW-1:0] got_d = '0;
    scrub_req = 1;
    tick();
    scrub_req = 0;
    req1 = 1; addr1 = 5; data1 = 50;
    for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
      tick();
      if (ack1 && done_cyc < 0) early_ack = 1;
      if (scrub_done) done_cyc = c;
      if (ack1 && done_cyc >= 0) begin
        ack_cyc = c; got_a = rf_caddr; got_d = rf_c; req1 = 0;
      end
    end
    req1 = 0;
    n_total++;
    if (early_ack) $display("FAIL scrub_req_early_ack: got ack1 during scrub, expected none");
    else n_pass++;
    n_total++;
    if (done_cyc < 0 || ack_cyc !== done_cyc + 1)
      $display("FAIL scrub_req_ack_timing: got done at %0d ack1 at %0d, expected ack1 one cycle after done", done_cyc, ack_cyc);
    else n_pass++;
    n_total++;
    if ({got_a, got_d} !== {4'd5, 16'd50})
      $display("FAIL scrub_req_write: got caddr=%0d c=%0d, expected 5 50", got_a, got_d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scrub();
    bit seen = 0;
    bit bad = 0;
    scrub_req = 1;
    tick();
    scrub_req = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (rf_load && rf_caddr == 7) seen = 1;
    end
    n_total++;
    if (!seen) $display("FAIL midscrub_reach7: got no write to address 7 in 20 cycles, expected one");
    else n_pass++;
    clear = 1;
    #1;
    n_total++;
    if ({rf_load, ack0, ack1, busy, scrub_done, rf_c, rf_caddr} !== '0)
      $display("FAIL midscrub_clear_async: got load=%b busy=%b done=%b caddr=%0d, expected all 0",
               rf_load, busy, scrub_done, rf_caddr);
    else n_pass++;
    tick();
    clear = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (scrub_done || rf_load || busy) bad = 1;
    end
    n_total++;
    if (bad) $display("FAIL midscrub_aborted: got activity after clear released, expected idle without scrub_done");
    else n_pass++;
  endtask

  // Reference: scrub progress is a position in the address list, arbitration
  // is "serve whoever wasn't served last", evaluated on the inputs seen at each edge.
  task automatic test_random();
    int m_pos, m_last, errs;
    logic e_load, e_ack0, e_ack1, e_busy, e_done;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    do_clear();
    req0 = 0; req1 = 0; scrub_req = 0;
    m_pos = -1; m_last = 1; errs = 0;
    e_load = 0; e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_done = 0; e_a = '0; e_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit el0, el1;
      int win;
      el0 = req0 && !e_ack0;
      el1 = req1 && !e_ack1;
      e_load = 0; e_ack0 = 0; e_ack1 = 0; e_done = 0;
      if (m_pos < 0) begin
        if (scrub_req) begin
          m_pos = 0; e_busy = 1;
        end else if (el0 || el1) begin
          win = (el0 && el1) ? (m_last == 0 ? 1 : 0) : (el0 ? 0 : 1);
          m_last = win;
          e_load = 1;
          e_a = win == 0 ? addr0 : addr1;
          e_d = win == 0 ? data0 : data1;
          if (win == 0) e_ack0 = 1; else e_ack1 = 1;
        end
      end else if (m_pos == NR) begin
        m_pos = -1; e_busy = 0; e_done = 1;
      end else begin
        e_load = 1; e_a = AW'(m_pos); e_d = '0; m_pos++;
      end
      tick();
      n_total++;
      if ({rf_load, ack0, ack1, busy, scrub_done, rf_caddr, rf_c} !== {e_load, e_ack0, e_ack1, e_busy, e_done, e_a, e_d}) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_cyc%0d: got load=%b a0=%b a1=%b busy=%b done=%b caddr=%0d c=%0h, expected %b %b %b %b %b %0d %0h",
                   cyc, rf_load, ack0, ack1, busy, scrub_done, rf_caddr, rf_c,
                   e_load, e_ack0, e_ack1, e_busy, e_done, e_a, e_d);
      end else n_pass++;
      if (e_ack0 || !req0) begin
        req0 = ($urandom_range(0, 2) != 0);
        addr0 = AW'($urandom); data0 = DW'($urandom);
      end
      if (e_ack1 || !req1) begin
        req1 = ($urandom_range(0, 2) != 0);
        addr1 = AW'($urandom); data1 = DW'($urandom);
      end
      scrub_req = ($urandom_range(0, 39) == 0);
    end
    req0 = 0; req1 = 0; scrub_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_scrub();
    test_scrub_vs_req();
    test_reset_mid_scrub();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_write_ctrl.md
RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 Parameter: DATA_W, default 16, register data width.
REQ-002 Parameter: ADDR_W, default 4, register address width.
REQ-003 Parameter: NREGS, default 16, number of registers swept by a scrub.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: clear  in  1  reset, asynchronous, active-high.
REQ-006 Port: req0  in  1  write request, requester 0 (ALU writeback).
REQ-007 Port: addr0  in  ADDR_W  target register, requester 0.
REQ-008 Port: data0  in  DATA_W  write data, requester 0.
REQ-009 Port: req1  in  1  write request, requester 1 (memory load).
REQ-010 Port: addr1  in  ADDR_W  target register, requester 1.
REQ-011 Port: data1  in  DATA_W  write data, requester 1.
REQ-012 Port: scrub_req  in  1  request to zero all registers.
REQ-013 Port: rf_c  out  DATA_W  register-file write data.
REQ-014 Port: rf_caddr  out  ADDR_W  register-file write address.
REQ-015 Port: rf_load  out  1  register-file write enable.
REQ-016 Port: ack0  out  1  one-cycle grant/commit pulse, requester 0.
REQ-017 Port: ack1  out  1  one-cycle grant/commit pulse, requester 1.
REQ-018 Port: busy  out  1  high while a scrub is in progress.
REQ-019 Port: scrub_done  out  1  one-cycle pulse after the last scrub write.

Function
REQ-020 States SHALL be IDLE and SCRUB.
REQ-021 All outputs SHALL be registered.
REQ-022 rf_load, ack0, ack1 and scrub_done SHALL default to 0 in every cycle not explicitly driving them.
REQ-023 rf_c and rf_caddr SHALL hold their last value when rf_load is 0.
REQ-024 In IDLE, scrub_req=1 SHALL take priority over all requests: next state SCRUB, scrub counter 0, busy 1, no ack.
REQ-025 In IDLE without scrub_req, a requester SHALL be eligible when its req=1 and its ack is not currently 1, which masks double grants.
REQ-026 One eligible requester SHALL be granted: next cycle rf_load=1, rf_caddr/rf_c = that requester's addr/data, and its ack=1, all in the same cycle.
REQ-027 Two eligible requesters SHALL be resolved round-robin: grant the one not granted most recently; the pointer updates on every grant.
REQ-028 Requesters SHALL hold addr/data stable while req=1 and until ack is seen; they may change or drop req at the edge where ack=1 is sampled.
REQ-029 A single requester's throughput SHALL be at most one write per 2 cycles; alternating requesters SHALL reach one write per cycle.
REQ-030 In SCRUB, each cycle SHALL drive rf_load=1, rf_caddr=counter, rf_c=0, and increment the counter.
REQ-031 After the write with rf_caddr=NREGS-1, the next cycle SHALL have scrub_done=1, busy=0, rf_load=0 and state IDLE.
REQ-032 Arbitration SHALL resume the cycle after scrub_done.
REQ-033 In SCRUB, req0/req1 SHALL be ignored (no ack); requests pend and are served afterwards.
REQ-034 scrub_req asserted during SCRUB SHALL be ignored; held high into IDLE, it starts a new scrub.
REQ-035 Equal addr0/addr1 SHALL need no special handling; writes commit in grant order.

Reset
REQ-036 clear=1 SHALL immediately force: state IDLE, all outputs 0, round-robin pointer favouring requester 0, scrub counter 0.
REQ-037 clear mid-scrub SHALL abort it without scrub_done; clear mid-grant SHALL drop the pending ack.

Structure
REQ-038 DATA_W/ADDR_W/NREGS defaults and the state encoding SHALL live in the shared CPU package.
REQ-039 The two-way round-robin picker SHALL be a sub-module rr_arb2 (inputs: eligible mask, pointer; output: one-hot grant).

Verification
REQ-040 Reset: clear=1 -> rf_load=0, ack0=ack1=0, busy=0, rf_c=0, rf_caddr=0.
REQ-041 Single write: req0=1, addr0=4, data0=15 -> next cycle rf_load=1, rf_caddr=4, rf_c=15, ack0=1; no second grant.
REQ-042 Contention: req0 and req1 held high (addr 4/5, data 15/30) -> grants alternate 0,1,0,1 on consecutive cycles.
REQ-043 Scrub: scrub_req pulse -> 16 cycles of rf_load=1 with rf_caddr 0..15 and rf_c=0, then scrub_done=1 for one cycle; busy high throughout.
REQ-044 Scrub vs request: req1=1 (addr1=5, data1=50) during scrub -> no ack1 until after scrub_done; then rf_caddr=5, rf_c=50.
REQ-045 Reset mid-scrub: clear at counter=7 -> outputs 0 at once, no scrub_done, IDLE on release.
